// File: rtl/game_pkg.sv
// Shared game types: direction encoding reused by Hero_move for decode,
// the button-controller state encoding, and small direction helpers.
package game_pkg;

    // Direction code; also the bit index of each button/pulse vector.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // IDLE: nothing latched; DELAY: waiting for the first repeat;
    // REPEAT: issuing periodic repeat pulses.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int NUM_BTNS = 4;

    // Picks one direction among simultaneous presses: up > down > left > right.
    function automatic dir_t pick_dir(input logic [NUM_BTNS-1:0] press);
        dir_t d;
        if (press[0]) begin
            d = DIR_UP;
        end else if (press[1]) begin
            d = DIR_DOWN;
        end else if (press[2]) begin
            d = DIR_LEFT;
        end else begin
            d = DIR_RIGHT;
        end
        return d;
    endfunction

    // One-hot pulse vector for a direction, indexed like the button vector.
    function automatic logic [NUM_BTNS-1:0] dir_onehot(input dir_t d);
        logic [NUM_BTNS-1:0] oh;
        oh = 4'b0001 << d;
        return oh;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button conditioner: two-flop synchroniser, counter-based debounce
// and a registered rising-edge flag on the debounced level.
module btn_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_1,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button level into the clk_1 domain.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Flip the stable level only after the synchronised level has disagreed
    // with it for DEBOUNCE_CYCLES consecutive cycles; flag a 0->1 flip.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                    rise   <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/direction_button_ctrl.sv
// Turns four bouncy push-buttons into single-cycle up/down/left/right move
// pulses for Hero_move, with priority arbitration and auto-repeat on hold.
module direction_button_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic clk_1,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic held
);

    // The repeat counter is shared by the delay and period countdowns.
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);

    // Button vectors are indexed by dir_t: bit 0 up, 1 down, 2 left, 3 right.
    logic [NUM_BTNS-1:0] raw_btn;
    logic [NUM_BTNS-1:0] stable;
    logic [NUM_BTNS-1:0] press;

    btn_state_t          state;
    btn_state_t          state_next;
    dir_t                dir;
    dir_t                dir_next;
    dir_t                press_dir;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_next;
    logic [NUM_BTNS-1:0] pulse;
    logic [NUM_BTNS-1:0] pulse_next;

    assign raw_btn = {btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_1 (clk_1),
            .rst   (rst),
            .raw   (raw_btn[i]),
            .stable(stable[i]),
            .rise  (press[i])
        );
    end

    assign press_dir = pick_dir(press);

    // Next-state logic: latch a new direction from IDLE, then count down to
    // the first repeat and each following repeat until that button releases.
    always_comb begin
        state_next = state;
        dir_next   = dir;
        cnt_next   = cnt;
        pulse_next = '0;
        unique case (state)
            IDLE: begin
                if (|press) begin
                    dir_next   = press_dir;
                    pulse_next = dir_onehot(press_dir);
                    cnt_next   = DELAY_LOAD;
                    state_next = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!stable[dir]) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    pulse_next = dir_onehot(dir);
                    cnt_next   = PERIOD_LOAD;
                    state_next = REPEAT;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, latched direction, countdown and registered move pulses.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            dir   <= DIR_UP;
            cnt   <= '0;
            pulse <= '0;
        end else begin
            state <= state_next;
            dir   <= dir_next;
            cnt   <= cnt_next;
            pulse <= pulse_next;
        end
    end

    assign up    = pulse[DIR_UP];
    assign down  = pulse[DIR_DOWN];
    assign left  = pulse[DIR_LEFT];
    assign right = pulse[DIR_RIGHT];
    assign held  = (state != IDLE);

endmodule
